// File: rtl/hesap_cekirdegi_if.sv
// Request/result bundle of the calculator arithmetic core.
// master drives requests and consumes results; slave is the core.
interface hesap_cekirdegi_if #(
    parameter int W     = 32,
    parameter int CNT_W = 16
);
    logic             giris_gecerli;
    logic             giris_hazir;
    logic [W-1:0]     sayi1;
    logic [W-1:0]     sayi2;
    logic [2:0]       tur;
    logic             iptal;
    logic             cikis_gecerli;
    logic             cikis_hazir;
    logic [2*W-1:0]   sonuc;
    logic             gecerli;
    logic             tasma;
    logic [CNT_W-1:0] tamamlanan;

    modport master (
        output giris_gecerli, sayi1, sayi2, tur, iptal, cikis_hazir,
        input  giris_hazir, cikis_gecerli, sonuc, gecerli, tasma, tamamlanan
    );

    modport slave (
        input  giris_gecerli, sayi1, sayi2, tur, iptal, cikis_hazir,
        output giris_hazir, cikis_gecerli, sonuc, gecerli, tasma, tamamlanan
    );
endinterface

// File: rtl/hesap_cekirdegi.sv
// Handshaked arithmetic core: add, sub, shift-add multiply, restoring divide
// and digit-by-digit integer square root on W-bit unsigned operands.
module hesap_cekirdegi #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst,
    hesap_cekirdegi_if.slave bus
);
    localparam int H  = W / 2;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [2:0]       op_r;
    logic [2*W-1:0]   prod;
    logic [W-1:0]     shl;
    logic [W-1:0]     rem;
    logic [H-1:0]     root;
    logic [H+1:0]     srem;
    logic [2*W-1:0]   sonuc_r;
    logic             gecerli_r;
    logic             tasma_r;
    logic [CNT_W-1:0] tamamlanan_r;

    logic [W:0]       mul_sum;
    logic [2*W-1:0]   prod_next;
    logic [W:0]       div_shift;
    logic [W:0]       div_diff;
    logic [W-1:0]     rem_next;
    logic [W-1:0]     quot_next;
    logic [H+3:0]     sq_shift;
    logic [H+3:0]     sq_trial;
    logic             sq_ge;
    logic [H+1:0]     srem_next;
    logic [H-1:0]     root_next;
    logic [W:0]       add_ab;
    logic [W:0]       sub_ab;
    logic [2*W-1:0]   res_val;
    logic             res_gecerli;
    logic             res_tasma;

    // shl carries the dividend (or radicand) out MSB-first while the
    // quotient bits enter at the bottom, so after W divide steps it is the quotient
    always_comb begin
        mul_sum   = {1'b0, prod[2*W-1:W]} + {1'b0, a_r};
        prod_next = prod[0] ? {mul_sum, prod[W-1:1]} : {1'b0, prod[2*W-1:1]};

        div_shift = {rem, shl[W-1]};
        div_diff  = div_shift - {1'b0, b_r};
        rem_next  = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
        quot_next = {shl[W-2:0], ~div_diff[W]};

        sq_shift  = {srem, shl[W-1:W-2]};
        sq_trial  = {2'b00, root, 2'b01};
        sq_ge     = (sq_shift >= sq_trial);
        srem_next = sq_ge ? (H+2)'(sq_shift - sq_trial) : (H+2)'(sq_shift);
        root_next = {root[H-2:0], sq_ge};
    end

    always_comb begin
        add_ab      = {1'b0, a_r} + {1'b0, b_r};
        sub_ab      = {1'b0, a_r} - {1'b0, b_r};
        res_val     = '0;
        res_gecerli = 1'b1;
        res_tasma   = 1'b0;
        case (op_r)
            3'b000: begin
                res_val   = {{(W-1){1'b0}}, add_ab};
                res_tasma = add_ab[W];
            end
            3'b001: begin
                res_val   = {{(W-1){sub_ab[W]}}, sub_ab};
                res_tasma = sub_ab[W];
            end
            3'b010: begin
                res_val   = prod_next;
                res_tasma = |prod_next[2*W-1:W];
            end
            3'b011: begin
                if (b_r == '0) res_gecerli = 1'b0;
                else           res_val     = {rem_next, quot_next};
            end
            3'b100:  res_val     = {W'(srem_next), W'(root_next)};
            default: res_gecerli = 1'b0;
        endcase
    end

    // Iteration count is fixed at accept time; the last CALC step writes the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            a_r          <= '0;
            b_r          <= '0;
            op_r         <= '0;
            prod         <= '0;
            shl          <= '0;
            rem          <= '0;
            root         <= '0;
            srem         <= '0;
            sonuc_r      <= '0;
            gecerli_r    <= 1'b0;
            tasma_r      <= 1'b0;
            tamamlanan_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.giris_gecerli) begin
                        a_r   <= bus.sayi1;
                        b_r   <= bus.sayi2;
                        op_r  <= bus.tur;
                        prod  <= {{W{1'b0}}, bus.sayi2};
                        shl   <= bus.sayi1;
                        rem   <= '0;
                        root  <= '0;
                        srem  <= '0;
                        state <= CALC;
                        case (bus.tur)
                            3'b010:  cnt <= CW'(W - 1);
                            3'b011:  cnt <= (bus.sayi2 == '0) ? '0 : CW'(W - 1);
                            3'b100:  cnt <= CW'(H - 1);
                            default: cnt <= '0;
                        endcase
                    end
                end
                CALC: begin
                    if (bus.iptal) begin
                        state <= IDLE;
                    end else begin
                        prod <= prod_next;
                        rem  <= rem_next;
                        srem <= srem_next;
                        root <= root_next;
                        shl  <= (op_r == 3'b100) ? {shl[W-3:0], 2'b00} : quot_next;
                        cnt  <= cnt - CW'(1);
                        if (cnt == '0) begin
                            sonuc_r   <= res_val;
                            gecerli_r <= res_gecerli;
                            tasma_r   <= res_tasma;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.cikis_hazir) begin
                        state        <= IDLE;
                        tamamlanan_r <= tamamlanan_r + CNT_W'(1);
                    end else if (bus.iptal) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.giris_hazir   = (state == IDLE);
    assign bus.cikis_gecerli = (state == DONE);
    assign bus.sonuc         = sonuc_r;
    assign bus.gecerli       = gecerli_r;
    assign bus.tasma         = tasma_r;
    assign bus.tamamlanan    = tamamlanan_r;
endmodule

// File: tb/tb_hesap_cekirdegi.sv
// Bench for hesap_cekirdegi: directed cases plus random operations checked
// against an arithmetic reference model; small counter width exercises wrap.
module tb_hesap_cekirdegi;
    localparam int W     = 32;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hesap_cekirdegi_if #(.W(W), .CNT_W(CNT_W)) bus ();

    hesap_cekirdegi #(.W(W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int             checks     = 0;
    int             failures   = 0;
    int             modelCount = 0;
    logic [2*W-1:0] expSonuc;
    logic           expGecerli;
    logic           expTasma;
    int             expN;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected result straight from the arithmetic definitions
    function automatic void refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        longint unsigned ua  = 64'(a);
        longint unsigned ub  = 64'(b);
        longint unsigned lim = 64'd1 << W;
        longint unsigned r;
        expSonuc   = '0;
        expGecerli = 1'b1;
        expTasma   = 1'b0;
        expN       = 1;
        case (op)
            3'd0: begin expSonuc = ua + ub; expTasma = (ua + ub) >= lim; end
            3'd1: begin expSonuc = ua - ub; expTasma = (ua < ub); end
            3'd2: begin expSonuc = ua * ub; expTasma = (ua * ub) >= lim; expN = W; end
            3'd3: begin
                if (ub == 0) expGecerli = 1'b0;
                else begin
                    expSonuc = ((ua % ub) << W) | (ua / ub);
                    expN     = W;
                end
            end
            3'd4: begin
                r = longint'($sqrt(real'(ua)));
                while (r * r > ua) r--;
                while ((r + 1) * (r + 1) <= ua) r++;
                expSonuc = ((ua - r * r) << W) | r;
                expN     = W / 2;
            end
            default: expGecerli = 1'b0;
        endcase
    endfunction

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, input bit withIptal);
        refModel(a, b, op);
        @(negedge clk);
        checkOutput("ready_idle", bus.giris_hazir, 1);
        bus.sayi1         = a;
        bus.sayi2         = b;
        bus.tur           = op;
        bus.giris_gecerli = 1'b1;
        bus.iptal         = withIptal;
        bus.cikis_hazir   = 1'b0;
        @(posedge clk);
        #1;
        bus.giris_gecerli = 1'b0;
        bus.iptal         = 1'b0;
        bus.sayi1         = $urandom;
        bus.sayi2         = $urandom;
        bus.tur           = 3'($urandom);
        checkOutput("busy_after_accept", bus.giris_hazir, 0);
    endtask

    task automatic waitResult();
        int lat = 0;
        while (bus.cikis_gecerli !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", lat, expN);
        checkOutput("sonuc", bus.sonuc, expSonuc);
        checkOutput("gecerli", bus.gecerli, expGecerli);
        checkOutput("tasma", bus.tasma, expTasma);
    endtask

    task automatic finishOp(input int holdCycles, input bit withIptal);
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            bus.giris_gecerli = 1'b1;
            checkOutput("hold_valid", bus.cikis_gecerli, 1);
            checkOutput("hold_not_ready", bus.giris_hazir, 0);
            checkOutput("hold_sonuc", bus.sonuc, expSonuc);
            checkOutput("hold_flags", {bus.gecerli, bus.tasma}, {expGecerli, expTasma});
        end
        @(negedge clk);
        bus.giris_gecerli = 1'b0;
        bus.cikis_hazir   = 1'b1;
        bus.iptal         = withIptal;
        @(posedge clk);
        #1;
        bus.cikis_hazir = 1'b0;
        bus.iptal       = 1'b0;
        modelCount      = (modelCount + 1) % (1 << CNT_W);
        checkOutput("after_hs_valid", bus.cikis_gecerli, 0);
        checkOutput("after_hs_ready", bus.giris_hazir, 1);
        checkOutput("tamamlanan", bus.tamamlanan, modelCount);
    endtask

    initial begin
        rst               = 1'b1;
        bus.giris_gecerli = 1'b0;
        bus.sayi1         = '0;
        bus.sayi2         = '0;
        bus.tur           = '0;
        bus.iptal         = 1'b0;
        bus.cikis_hazir   = 1'b0;
        #1;
        checkOutput("rst_hazir", bus.giris_hazir, 1);
        checkOutput("rst_valid", bus.cikis_gecerli, 0);
        checkOutput("rst_sonuc", bus.sonuc, 0);
        checkOutput("rst_flags", {bus.gecerli, bus.tasma}, 2'b00);
        checkOutput("rst_count", bus.tamamlanan, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(32'hFFFF_FFFF, 32'd1, 3'b000, 1'b0);
        waitResult();
        checkOutput("add_carry_const", {bus.sonuc, bus.tasma}, {64'h0000_0001_0000_0000, 1'b1});
        finishOp(0, 1'b0);

        applyStimulus(32'd3, 32'd5, 3'b001, 1'b0);
        waitResult();
        checkOutput("sub_borrow_const", bus.sonuc, 64'hFFFF_FFFF_FFFF_FFFE);
        finishOp(0, 1'b0);

        applyStimulus(32'h1_0000, 32'h1_0000, 3'b010, 1'b0);
        waitResult();
        checkOutput("mul_const", {bus.sonuc, bus.tasma}, {64'h1_0000_0000, 1'b1});
        finishOp(0, 1'b0);

        applyStimulus(32'd15, 32'd99, 3'b100, 1'b0);
        waitResult();
        checkOutput("sqrt15_const", bus.sonuc, {32'd6, 32'd3});
        finishOp(0, 1'b0);

        applyStimulus(32'd1000000, 32'd0, 3'b100, 1'b0);
        waitResult();
        checkOutput("sqrt1e6_const", bus.sonuc, {32'd0, 32'd1000});
        finishOp(5, 1'b0);

        applyStimulus(32'd100, 32'd7, 3'b011, 1'b0);
        waitResult();
        checkOutput("div_const", bus.sonuc, {32'd2, 32'd14});
        finishOp(0, 1'b0);

        applyStimulus(32'd100, 32'd0, 3'b011, 1'b0);
        waitResult();
        finishOp(0, 1'b0);

        applyStimulus(32'd42, 32'd17, 3'b110, 1'b0);
        waitResult();
        finishOp(0, 1'b0);

        // Abort a multiply partway through
        applyStimulus(32'h1234, 32'h5678, 3'b010, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        bus.iptal = 1'b1;
        @(posedge clk);
        #1;
        bus.iptal = 1'b0;
        checkOutput("abort_ready", bus.giris_hazir, 1);
        checkOutput("abort_valid", bus.cikis_gecerli, 0);
        checkOutput("abort_count", bus.tamamlanan, modelCount);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("abort_no_result", bus.cikis_gecerli, 0);

        // Abort while the result waits for the consumer
        applyStimulus(32'd7, 32'd8, 3'b000, 1'b0);
        waitResult();
        @(negedge clk);
        bus.iptal = 1'b1;
        @(posedge clk);
        #1;
        bus.iptal = 1'b0;
        checkOutput("abort_done_ready", bus.giris_hazir, 1);
        checkOutput("abort_done_count", bus.tamamlanan, modelCount);

        applyStimulus(32'd9, 32'd4, 3'b001, 1'b0);
        waitResult();
        finishOp(1, 1'b1);

        applyStimulus(32'd77, 32'd5, 3'b011, 1'b1);
        waitResult();
        finishOp(0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic [2:0]   rop;
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            rop = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
            applyStimulus(ra, rb, rop, 1'b0);
            waitResult();
            finishOp($urandom_range(0, 2), $urandom_range(0, 3) == 0);
        end

        // Reset in the middle of a divide clears everything without a clock edge
        applyStimulus(32'd100, 32'd7, 3'b011, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_hazir", bus.giris_hazir, 1);
        checkOutput("midrst_valid", bus.cikis_gecerli, 0);
        checkOutput("midrst_sonuc", bus.sonuc, 0);
        checkOutput("midrst_flags", {bus.gecerli, bus.tasma}, 2'b00);
        checkOutput("midrst_count", bus.tamamlanan, 0);
        @(negedge clk);
        rst        = 1'b0;
        modelCount = 0;

        applyStimulus(32'd5, 32'd6, 3'b010, 1'b0);
        waitResult();
        finishOp(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
